printer_alarm_mgr: RTL and testbench

//  Parametrised, clocked successor of the printer alarm decoder. Synchronises and

---
 rtl/printer_alarm_pkg.sv | 21 ++
 rtl/alarm_chan_fsm.sv | 68 ++++++
 rtl/printer_alarm_mgr.sv | 144 ++++++++++++++
 tb/tb_printer_alarm_mgr.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/printer_alarm_pkg.sv
// -----------------------------------------------------------------------------
// printer_alarm_pkg
// Shared types and defaults for the printer alarm manager.
//   alarm_state_t       : per-alarm latch/acknowledge state
//   DEFAULT_ALARM_MAP   : alarm0 = jam|repair, alarm1 = jam|ink
//   DEFAULT_DEB_CYCLES  : debounce hold time in clock cycles
// -----------------------------------------------------------------------------
package printer_alarm_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACTIVE   = 2'd1,
        SILENCED = 2'd2
    } alarm_state_t;

    // Slice [j*3 +: 3] lists the sensors (bit0 jam, bit1 repair, bit2 ink)
    // that drive alarm j.
    localparam logic [5:0] DEFAULT_ALARM_MAP  = 6'b101011;
    localparam int         DEFAULT_DEB_CYCLES = 4;

endpackage

// File: rtl/alarm_chan_fsm.sv
// -----------------------------------------------------------------------------
// alarm_chan_fsm
// One latching alarm channel with operator acknowledge.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   cause       : level that raises the alarm
//   ack         : acknowledge level, sampled every cycle
//   alarm_out   : 1 while the channel is ACTIVE
//   state_dbg   : current state, for observation
//
// Acknowledge semantics: ack is a level, not a valid/ready handshake. It is
// only consumed in ACTIVE; one sampled high cycle moves the channel out of
// ACTIVE and any further high cycles are ignored until the channel re-arms.
// -----------------------------------------------------------------------------
module alarm_chan_fsm
    import printer_alarm_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cause,
    input  logic         ack,
    output logic         alarm_out,
    output alarm_state_t state_dbg
);

    alarm_state_t state, state_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        alarm_out = 1'b0;
        case (state)
            IDLE: begin
                // ack is deliberately ignored here, so an ack that races the
                // rising cause cannot swallow the alarm.
                if (cause) begin
                    state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                alarm_out = 1'b1;
                if (ack) begin
                    // Acked while the fault persists: stay quiet until it
                    // clears, otherwise return straight to IDLE.
                    state_nxt = cause ? SILENCED : IDLE;
                end
            end
            SILENCED: begin
                if (!cause) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign state_dbg = state;

endmodule

// File: rtl/printer_alarm_mgr.sv
// -----------------------------------------------------------------------------
// printer_alarm_mgr
// Synchronises and debounces raw printer fault sensors, maps them onto alarms
// through a bit mask, adds a multi-fault alarm, and latches every alarm until
// the operator acknowledges it.
// Ports:
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   sens_raw     : raw asynchronous sensor levels, 1 = fault
//   ack          : per-alarm acknowledge
//   ack_multi    : acknowledge for alarm_multi
//   sens_stable  : debounced sensor levels
//   fault_cnt    : registered popcount of sens_stable
//   alarm        : mask-mapped alarm outputs
//   alarm_multi  : raised while fault_cnt >= MULTI_THRESH (latching)
// -----------------------------------------------------------------------------
module printer_alarm_mgr
    import printer_alarm_pkg::*;
#(
    parameter int N_SENS       = 3,
    parameter int N_ALARM      = 2,
    parameter int DEB_CYCLES   = DEFAULT_DEB_CYCLES,
    parameter int MULTI_THRESH = 2,
    parameter logic [N_ALARM*N_SENS-1:0] ALARM_MAP = DEFAULT_ALARM_MAP
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_SENS-1:0]           sens_raw,
    input  logic [N_ALARM-1:0]          ack,
    input  logic                        ack_multi,
    output logic [N_SENS-1:0]           sens_stable,
    output logic [$clog2(N_SENS+1)-1:0] fault_cnt,
    output logic [N_ALARM-1:0]          alarm,
    output logic                        alarm_multi
);

    localparam int CNT_W = $clog2(N_SENS + 1);
    localparam int DEB_W = $clog2(DEB_CYCLES + 1);
    // The counter toggles the output on the cycle it would reach DEB_CYCLES,
    // so the mismatch has been seen for exactly DEB_CYCLES edges.
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    // ---------------------------------------------------------------- sync
    logic [N_SENS-1:0] sync1, sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sens_raw;
            sync2 <= sync1;
        end
    end

    // ------------------------------------------------------------ debounce
    for (genvar gi = 0; gi < N_SENS; gi++) begin : g_deb
        logic [DEB_W-1:0] deb_cnt;
        logic             stable_bit;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                deb_cnt    <= '0;
                stable_bit <= 1'b0;
            end else if (sync2[gi] != stable_bit) begin
                if (deb_cnt == DEB_LAST) begin
                    stable_bit <= ~stable_bit;
                    deb_cnt    <= '0;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end else begin
                // Any run shorter than DEB_CYCLES is forgotten here.
                deb_cnt <= '0;
            end
        end

        assign sens_stable[gi] = stable_bit;
    end

    // ------------------------------------------------------------ popcount
    logic [CNT_W-1:0] pop;

    always_comb begin
        pop = '0;
        for (int i = 0; i < N_SENS; i++) begin
            pop = pop + CNT_W'(sens_stable[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_cnt <= '0;
        end else begin
            fault_cnt <= pop;
        end
    end

    // -------------------------------------------------------------- causes
    logic [N_ALARM-1:0] cause;
    logic               cause_multi;

    always_comb begin
        cause = '0;
        for (int j = 0; j < N_ALARM; j++) begin
            cause[j] = |(sens_stable & ALARM_MAP[j*N_SENS +: N_SENS]);
        end
    end

    // Driven from the registered count, so alarm_multi trails the mapped
    // alarms by one cycle.
    assign cause_multi = (fault_cnt >= CNT_W'(MULTI_THRESH));

    // -------------------------------------------------------------- alarms
    alarm_state_t chan_state [N_ALARM+1];

    for (genvar gj = 0; gj < N_ALARM; gj++) begin : g_chan
        alarm_chan_fsm u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .cause     (cause[gj]),
            .ack       (ack[gj]),
            .alarm_out (alarm[gj]),
            .state_dbg (chan_state[gj])
        );
    end

    alarm_chan_fsm u_multi (
        .clk       (clk),
        .rst_n     (rst_n),
        .cause     (cause_multi),
        .ack       (ack_multi),
        .alarm_out (alarm_multi),
        .state_dbg (chan_state[N_ALARM])
    );

    // The unused encoding 2'b11 must never be reached.
    for (genvar gk = 0; gk <= N_ALARM; gk++) begin : g_state_chk
        a_state_legal : assert property (
            @(posedge clk) disable iff (!rst_n) chan_state[gk] != 2'b11
        );
    end

endmodule

// File: tb/tb_printer_alarm_mgr.sv
// -----------------------------------------------------------------------------
// tb_printer_alarm_mgr
// Directed scenarios followed by randomized sensor/ack traffic. Each clock
// edge the reference model computes the expected outputs and queues them; a
// monitor on the falling edge compares the DUT outputs against the queue.
// -----------------------------------------------------------------------------
module tb_printer_alarm_mgr;

    localparam int N_SENS  = 3;
    localparam int N_ALARM = 2;
    localparam int DEB     = 4;
    localparam int MT      = 2;
    localparam int W       = 8;  // {sens_stable[3], fault_cnt[2], alarm[2], alarm_multi}

    // ------------------------------------------------------ clock / reset
    logic clk;
    logic rst_n;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [N_SENS-1:0]  sens_raw;
    logic [N_ALARM-1:0] ack;
    logic               ack_multi;
    logic [N_SENS-1:0]  sens_stable;
    logic [1:0]         fault_cnt;
    logic [N_ALARM-1:0] alarm;
    logic               alarm_multi;

    printer_alarm_mgr dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sens_raw    (sens_raw),
        .ack         (ack),
        .ack_multi   (ack_multi),
        .sens_stable (sens_stable),
        .fault_cnt   (fault_cnt),
        .alarm       (alarm),
        .alarm_multi (alarm_multi)
    );

    wire [W-1:0] dut_vec = {sens_stable, fault_cnt, alarm, alarm_multi};

    // ---------------------------------------------------------- scoreboard
    logic [W-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%b expected=%b", name, $time, act, exp);
        end
    endtask

    initial begin : monitor
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("cycle_outputs", dut_vec, e);
            end
        end
    end

    // ----------------------------------------------------- reference model
    // Sensors are seen two edges late; a debounced bit flips once the delayed
    // level has disagreed with it on DEB consecutive edges. Each alarm is
    // either raised, silenced (acked, fault still present) or quiet.
    logic [5:0]        map_v = 6'b101011;
    logic [N_SENS-1:0] raw_d1, raw_d2, m_stable;
    int                m_run [N_SENS];
    logic [1:0]        m_cnt;
    bit                m_raised   [N_ALARM+1];
    bit                m_silenced [N_ALARM+1];

    task automatic model_reset();
        raw_d1 = '0; raw_d2 = '0; m_stable = '0; m_cnt = '0;
        for (int i = 0; i < N_SENS; i++) m_run[i] = 0;
        for (int k = 0; k <= N_ALARM; k++) begin
            m_raised[k] = 0; m_silenced[k] = 0;
        end
    endtask

    task automatic model_edge(input logic [N_SENS-1:0] raw, input logic [N_ALARM-1:0] a, input logic am);
        logic [N_SENS-1:0] seen = raw_d2;
        logic [N_SENS-1:0] st   = m_stable;
        logic [1:0]        cnt  = m_cnt;
        bit cz [N_ALARM+1];
        bit az [N_ALARM+1];
        raw_d2 = raw_d1;
        raw_d1 = raw;
        for (int i = 0; i < N_SENS; i++) begin
            if (seen[i] != st[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    m_stable[i] = ~st[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_cnt = 2'($countones(st));
        for (int j = 0; j < N_ALARM; j++) begin
            cz[j] = (st & map_v[j*N_SENS +: N_SENS]) != 0;
            az[j] = a[j];
        end
        cz[N_ALARM] = (int'(cnt) >= MT);
        az[N_ALARM] = am;
        for (int k = 0; k <= N_ALARM; k++) begin
            if (m_raised[k]) begin
                if (az[k]) begin
                    m_raised[k]   = 0;
                    m_silenced[k] = cz[k];
                end
            end else if (m_silenced[k]) begin
                if (!cz[k]) m_silenced[k] = 0;
            end else if (cz[k]) begin
                m_raised[k] = 1;
            end
        end
    endtask

    function automatic logic [W-1:0] model_vec();
        return {m_stable, m_cnt, 1'(m_raised[1]), 1'(m_raised[0]), 1'(m_raised[2])};
    endfunction

    // ------------------------------------------------------- driver tasks
    // Called just after a rising edge: apply inputs, wait one edge, queue the
    // expected outputs for that edge.
    task automatic do_cycle(input logic [N_SENS-1:0] raw, input logic [N_ALARM-1:0] a, input logic am);
        sens_raw  = raw;
        ack       = a;
        ack_multi = am;
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_edge(raw, a, am);
        exp_q.push_back(model_vec());
        #1;
    endtask

    task automatic hold(input logic [N_SENS-1:0] raw, input int n);
        for (int i = 0; i < n; i++) do_cycle(raw, '0, 1'b0);
    endtask

    // Reset asserted between edges; outputs must drop with no clock edge.
    task automatic mid_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", dut_vec, '0);
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        exp_q.push_back('0);
        model_reset();
        @(posedge clk);
        #1;
        hold(sens_raw, 2);
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        rst_n = 1'b0;
        sens_raw = '0; ack = '0; ack_multi = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check("reset_outputs", dut_vec, '0);
        hold(3'b000, 3);
        rst_n = 1'b1;

        // glitch shorter than the debounce window
        hold(3'b001, 3);
        hold(3'b000, 12);

        // single jam, latch after release, per-alarm acks
        hold(3'b001, 10);
        hold(3'b000, 10);
        do_cycle(3'b000, 2'b01, 1'b0);
        hold(3'b000, 3);
        do_cycle(3'b000, 2'b10, 1'b0);
        hold(3'b000, 3);

        // multi-fault, silence, release, re-arm
        hold(3'b110, 12);
        do_cycle(3'b110, 2'b00, 1'b1);
        hold(3'b110, 3);
        hold(3'b000, 12);
        hold(3'b110, 12);

        // reset with alarms and alarm_multi raised, sensors held
        mid_reset();
        hold(3'b110, 12);

        // clear everything, then ack racing the rising cause
        hold(3'b000, 12);
        do_cycle(3'b000, 2'b11, 1'b1);
        hold(3'b000, 2);
        hold(3'b001, 6);
        do_cycle(3'b001, 2'b01, 1'b0);
        hold(3'b001, 4);
        do_cycle(3'b001, 2'b01, 1'b0);
        hold(3'b001, 3);

        // random traffic
        for (int seg = 0; seg < 80; seg++) begin
            logic [N_SENS-1:0] r;
            int len;
            r   = N_SENS'($urandom_range(0, 7));
            len = $urandom_range(1, 12);
            for (int c = 0; c < len; c++) begin
                logic [N_ALARM-1:0] a;
                logic am;
                a  = ($urandom_range(0, 5) == 0) ? N_ALARM'($urandom_range(0, 3)) : '0;
                am = ($urandom_range(0, 5) == 0);
                do_cycle(r, a, am);
            end
            if ($urandom_range(0, 24) == 0) mid_reset();
        end

        hold(sens_raw, 2);
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drained got=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
